i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one I2C master core between NUM_REQ on-chip requesters. It latches the winning requester's command (7-bit slave address, R/W, write byte) and issues it to the master with a start pulse. It waits for completion, or for a watchdog timeout, and then returns the ACK/NACK status and read byte to the granted requester. It sits between the system-side clients and the I2C master datapath that drives SDA/SCL.

---
 rtl/i2c_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter and transaction sequencer sharing one I2C master
module i2c_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]   req_rw,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic                 rsp_nack,
   output logic                 rsp_timeout,
   output logic [7:0]           rsp_rdata,
   output logic                 m_start,
   output logic                 m_abort,
   output logic [6:0]           m_addr,
   output logic                 m_rw,
   output logic [7:0]           m_wdata,
   input  logic                 m_busy,
   input  logic                 m_done,
   input  logic                 m_nack,
   input  logic [7:0]           m_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               rsp_nack_q, rsp_nack_d;
   logic               rsp_timeout_q, rsp_timeout_d;
   logic [7:0]         rsp_rdata_q, rsp_rdata_d;
   logic               m_start_q, m_start_d;
   logic               m_abort_q, m_abort_d;
   logic [6:0]         m_addr_q, m_addr_d;
   logic               m_rw_q, m_rw_d;
   logic [7:0]         m_wdata_q, m_wdata_d;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W:0]     cand;
   logic               expire;

   // Round-robin search: first active request at or after last winner + 1, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_REQ)) begin
            cand = cand - (IDX_W+1)'(NUM_REQ);
         end
         if (!pick_valid && req[cand[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign expire = (cnt_q == CNT_LAST);

   // State and registered-output flops; reset leaves requester 0 with top priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         last_q        <= IDX_W'(NUM_REQ - 1);
         win_q         <= '0;
         gnt_q         <= '0;
         done_q        <= '0;
         rsp_nack_q    <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         m_start_q     <= 1'b0;
         m_abort_q     <= 1'b0;
         m_addr_q      <= '0;
         m_rw_q        <= 1'b0;
         m_wdata_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         win_q         <= win_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         rsp_nack_q    <= rsp_nack_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
         m_start_q     <= m_start_d;
         m_abort_q     <= m_abort_d;
         m_addr_q      <= m_addr_d;
         m_rw_q        <= m_rw_d;
         m_wdata_q     <= m_wdata_d;
      end
   end

   // Next-state: grant, wait for an idle master, wait for completion or expiry, respond.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_valid) state_d = S_ISSUE;
         S_ISSUE: if (!m_busy) state_d = S_WAIT;
         S_WAIT:  if (m_done || expire) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; m_done is checked before expiry so it wins a tie.
   always_comb begin
      cnt_d         = cnt_q;
      last_d        = last_q;
      win_d         = win_q;
      gnt_d         = gnt_q;
      done_d        = '0;
      rsp_nack_d    = rsp_nack_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_rdata_d   = rsp_rdata_q;
      m_start_d     = 1'b0;
      m_abort_d     = 1'b0;
      m_addr_d      = m_addr_q;
      m_rw_d        = m_rw_q;
      m_wdata_d     = m_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               gnt_d     = NUM_REQ'(1) << pick_idx;
               win_d     = pick_idx;
               m_addr_d  = req_addr[7*pick_idx +: 7];
               m_rw_d    = req_rw[pick_idx];
               m_wdata_d = req_wdata[8*pick_idx +: 8];
            end
         end
         S_ISSUE: begin
            if (!m_busy) m_start_d = 1'b1;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (m_done) begin
               done_d        = gnt_q;
               rsp_nack_d    = m_nack;
               rsp_rdata_d   = m_rdata;
               rsp_timeout_d = 1'b0;
            end else if (expire) begin
               done_d        = gnt_q;
               m_abort_d     = 1'b1;
               rsp_nack_d    = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end
         end
         S_RESP: begin
            gnt_d  = '0;
            last_d = win_q;
            cnt_d  = '0;
         end
         default: ;
      endcase
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign rsp_nack    = rsp_nack_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign m_start     = m_start_q;
   assign m_abort     = m_abort_q;
   assign m_addr      = m_addr_q;
   assign m_rw        = m_rw_q;
   assign m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [7*N-1:0] req_addr = '0;
   logic [N-1:0]   req_rw = '0;
   logic [8*N-1:0] req_wdata = '0;
   logic [N-1:0]   gnt, done;
   logic           rsp_nack, rsp_timeout;
   logic [7:0]     rsp_rdata;
   logic           m_start, m_abort;
   logic [6:0]     m_addr;
   logic           m_rw;
   logic [7:0]     m_wdata;
   logic           m_busy = 1'b0;
   logic           m_done = 1'b0;
   logic           m_nack = 1'b0;
   logic [7:0]     m_rdata = '0;

   int             total = 0;
   int             bad = 0;
   logic [N-1:0]   seen_gnt;

   always #5 clk = ~clk;

   i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .req(req), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .gnt(gnt), .done(done),
      .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
      .m_start(m_start), .m_abort(m_abort),
      .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
      .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
   );

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_gnt();
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (gnt !== '0) hit = 1;
      end
      seen_gnt = gnt;
      if (!hit) begin
         total++; bad++;
         $display("FAIL wait_gnt: no grant within bound, gnt=%b", gnt);
      end
   endtask

   task automatic wait_start();
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (m_start === 1'b1) hit = 1;
      end
      if (!hit) begin
         total++; bad++;
         $display("FAIL wait_start: no m_start within bound");
      end
   endtask

   task automatic finish_txn(input logic nack_in, input logic [7:0] rdata_in);
      wait_start();
      m_done = 1'b1; m_nack = nack_in; m_rdata = rdata_in;
      @(negedge clk);
      m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if ({gnt, done, m_start, m_abort} !== '0) begin
         bad++; $display("FAIL reset_ctrl: got %b required 0", {gnt, done, m_start, m_abort});
      end
      total++;
      if ({rsp_nack, rsp_timeout, rsp_rdata} !== '0) begin
         bad++; $display("FAIL reset_rsp: got %h required 0", {rsp_nack, rsp_timeout, rsp_rdata});
      end
      total++;
      if ({m_addr, m_rw, m_wdata} !== '0) begin
         bad++; $display("FAIL reset_fields: got %h required 0", {m_addr, m_rw, m_wdata});
      end
   endtask

   task automatic test_write();
      do_reset();
      @(negedge clk);
      req = 4'b0001; req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_wdata[7:0] = 8'hAA;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0001 || m_start !== 1'b0) begin
         bad++; $display("FAIL write_gnt: gnt=%b m_start=%b required 0001/0", gnt, m_start);
      end
      @(negedge clk);
      total++;
      if (m_start !== 1'b1) begin
         bad++; $display("FAIL write_start: got %b required 1", m_start);
      end
      total++;
      if (m_addr !== 7'h50 || m_wdata !== 8'hAA || m_rw !== 1'b0) begin
         bad++; $display("FAIL write_fields: addr=%h wdata=%h rw=%b required 50/aa/0", m_addr, m_wdata, m_rw);
      end
      m_done = 1'b1; m_nack = 1'b0;
      @(negedge clk);
      m_done = 1'b0;
      total++;
      if (done !== 4'b0001 || gnt !== 4'b0001 || m_start !== 1'b0) begin
         bad++; $display("FAIL write_done: done=%b gnt=%b m_start=%b required 0001/0001/0", done, gnt, m_start);
      end
      total++;
      if (rsp_nack !== 1'b0 || rsp_timeout !== 1'b0) begin
         bad++; $display("FAIL write_rsp: nack=%b timeout=%b required 0/0", rsp_nack, rsp_timeout);
      end
      req = '0;
      @(negedge clk);
      total++;
      if (done !== '0 || gnt !== '0) begin
         bad++; $display("FAIL write_after: done=%b gnt=%b required 0/0", done, gnt);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0010};
      do_reset();
      req = 4'b0101;
      for (int k = 0; k < 6; k++) begin
         wait_gnt();
         total++;
         if (seen_gnt !== exp_seq[k]) begin
            bad++; $display("FAIL rr_gnt%0d: got %b required %b", k, seen_gnt, exp_seq[k]);
         end
         if (k == 3) req = 4'b0111;
         finish_txn(1'b0, 8'h00);
         total++;
         if (done !== exp_seq[k]) begin
            bad++; $display("FAIL rr_done%0d: got %b required %b", k, done, exp_seq[k]);
         end
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_read_nack();
      do_reset();
      req = 4'b1000; req_addr[27:21] = 7'h21; req_rw[3] = 1'b1; req_wdata[31:24] = 8'h11;
      wait_gnt();
      total++;
      if (seen_gnt !== 4'b1000 || m_rw !== 1'b1 || m_addr !== 7'h21) begin
         bad++; $display("FAIL rd_gnt: gnt=%b rw=%b addr=%h required 1000/1/21", seen_gnt, m_rw, m_addr);
      end
      req = '0; req_addr[27:21] = 7'h7F; req_rw[3] = 1'b0;
      finish_txn(1'b1, 8'h3C);
      total++;
      if (done !== 4'b1000 || rsp_nack !== 1'b1 || rsp_rdata !== 8'h3C || rsp_timeout !== 1'b0) begin
         bad++; $display("FAIL rd_done: done=%b nack=%b rdata=%h to=%b required 1000/1/3c/0",
                         done, rsp_nack, rsp_rdata, rsp_timeout);
      end
      total++;
      if (m_addr !== 7'h21 || m_rw !== 1'b1) begin
         bad++; $display("FAIL rd_latched: addr=%h rw=%b required 21/1", m_addr, m_rw);
      end
      @(negedge clk);
      total++;
      if (done !== '0 || gnt !== '0 || rsp_rdata !== 8'h3C || rsp_nack !== 1'b1) begin
         bad++; $display("FAIL rd_hold: done=%b gnt=%b rdata=%h nack=%b required 0/0/3c/1",
                         done, gnt, rsp_rdata, rsp_nack);
      end
   endtask

   task automatic test_timeout();
      bit early = 0;
      do_reset();
      req = 4'b0010;
      wait_gnt();
      wait_start();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (m_abort !== 1'b0 || done !== '0) early = 1;
      end
      total++;
      if (early !== 1'b0) begin
         bad++; $display("FAIL to_early: got %b required 0", early);
      end
      @(negedge clk);
      total++;
      if (m_abort !== 1'b1 || done !== 4'b0010) begin
         bad++; $display("FAIL to_abort: abort=%b done=%b required 1/0010", m_abort, done);
      end
      total++;
      if (rsp_timeout !== 1'b1 || rsp_nack !== 1'b1 || rsp_rdata !== 8'h00) begin
         bad++; $display("FAIL to_rsp: to=%b nack=%b rdata=%h required 1/1/00", rsp_timeout, rsp_nack, rsp_rdata);
      end
      req = '0;
      @(negedge clk);
      total++;
      if (m_abort !== 1'b0 || done !== '0 || gnt !== '0) begin
         bad++; $display("FAIL to_after: abort=%b done=%b gnt=%b required 0/0/0", m_abort, done, gnt);
      end
   endtask

   task automatic test_busy();
      bit seen = 0;
      do_reset();
      m_busy = 1'b1;
      req = 4'b0001;
      wait_gnt();
      for (int i = 0; i < 10; i++) begin
         m_done = (i == 4);
         @(negedge clk);
         if (m_start !== 1'b0 || done !== '0) seen = 1;
      end
      m_done = 1'b0;
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL busy_hold: got %b required 0", seen);
      end
      m_busy = 1'b0;
      @(negedge clk);
      total++;
      if (m_start !== 1'b1) begin
         bad++; $display("FAIL busy_start: got %b required 1", m_start);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_abort !== 1'b0 || done !== '0) seen = 1;
      end
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      total++;
      if (seen !== 1'b0 || done !== 4'b0001 || rsp_timeout !== 1'b0) begin
         bad++; $display("FAIL busy_done: early=%b done=%b to=%b required 0/0001/0", seen, done, rsp_timeout);
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_wait();
      do_reset();
      req = 4'b0100;
      wait_gnt();
      wait_start();
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if (gnt !== '0 || done !== '0 || m_start !== 1'b0 || m_abort !== 1'b0) begin
         bad++; $display("FAIL rst_async: gnt=%b done=%b start=%b abort=%b required 0",
                         gnt, done, m_start, m_abort);
      end
      req = 4'b0011;
      repeat (2) @(negedge clk);
      total++;
      if (done !== '0 || m_abort !== 1'b0) begin
         bad++; $display("FAIL rst_quiet: done=%b abort=%b required 0/0", done, m_abort);
      end
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0001) begin
         bad++; $display("FAIL rst_regrant: got %b required 0001", gnt);
      end
      finish_txn(1'b0, 8'h00);
      total++;
      if (done !== 4'b0001) begin
         bad++; $display("FAIL rst_done: got %b required 0001", done);
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_round_robin();
      test_read_nack();
      test_timeout();
      test_busy();
      test_reset_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
